// File: rtl/fifo_uart_tx.sv
// UART transmitter draining an upstream FIFO: IDLE->REQ->WAIT->frame.
// Optional even parity bit when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk_single_domain,
  input  logic       rst,
  input  logic       empty,
  input  logic [7:0] rdata,
  input  logic       rvalid,
  output logic       ren,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    START,
    DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          t_last;
  logic          ren_c, done_c;

  assign t_last = (timer_q == T_LAST);

  always_ff @(posedge clk_single_domain) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    ren_c   = 1'b0;
    done_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) state_d = REQ;
      end
      REQ: begin
        ren_c   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (rvalid) begin
          shreg_d = rdata;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (t_last) state_d = DATA;
      end
      DATA: begin
        if (t_last) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (t_last) state_d = STOP;
      end
`endif
      STOP: begin
        if (t_last) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit timer runs only while a frame is on the line
  always_comb begin
    timer_d = '0;
    if (state_q == START || state_q == DATA ||
`ifdef FIFO_UART_TX_PARITY_EN
        state_q == PARITY ||
`endif
        state_q == STOP) begin
      timer_d = t_last ? '0 : timer_q + 1'b1;
    end
  end

  // tx is registered, so it is computed from the upcoming state
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shreg_d[idx_d];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: tx_d = ^shreg_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);
  assign ren       = ren_c & ~rst;
  assign byte_done = done_c & ~rst;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: upstream FIFO model drives stimulus,
// monitor checks the serial line cycle by cycle against queued frames.
module tb_fifo_uart_tx;

  localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int L = NB * C;

  logic       clk_single_domain = 1'b0;
  logic       rst = 1'b1;
  logic       empty = 1'b1;
  logic [7:0] rdata = 8'h00;
  logic       rvalid = 1'b0;
  logic       ren, tx, busy, byte_done;

  fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk_single_domain(clk_single_domain),
    .rst(rst),
    .empty(empty),
    .rdata(rdata),
    .rvalid(rvalid),
    .ren(ren),
    .tx(tx),
    .busy(busy),
    .byte_done(byte_done)
  );

  always #5 clk_single_domain = ~clk_single_domain;

  int cyc = 0;
  always @(posedge clk_single_domain) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    int         start;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic exp_bit(logic [7:0] b, int k);
    int i;
    i = k / C;
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef FIFO_UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Monitor: samples just after each rising edge
  initial begin : monitor
    bit   inf;
    int   k;
    exp_t cur;
    inf = 0;
    k = 0;
    forever begin
      @(posedge clk_single_domain);
      #1;
      if (rst) begin
        inf = 0;
        continue;
      end
      if (!inf && exp_q.size() > 0 && exp_q[0].start == cyc) begin
        cur = exp_q.pop_front();
        inf = 1;
        k = 0;
      end
      if (inf) begin
        chk("frame_tx", tx, exp_bit(cur.b, k));
        chk("frame_done", byte_done, k == L - 1);
        k++;
        if (k == L) inf = 0;
      end else begin
        chk("idle_tx", tx, 1);
        chk("idle_done", byte_done, 0);
      end
    end
  end

  typedef enum {M_IDLE, M_REQ, M_WAIT, M_FRAME} m_t;
  m_t         m = M_IDLE;
  int         fstart = 0;
  int         fend = 0;
  bit         prev_rst = 0;
  int         rst_left = 0;
  int         p_hold = 0, p_drop = 0, p_stray = 0, p_rst = 0;
  bit         force_drop = 0;
  logic [7:0] src[$];

  // Upstream FIFO plus transaction-level model of the transmitter
  task automatic step();
    int  c;
    bit  rnow;
    bit  drop;
    m_t  m_old;
    @(negedge clk_single_domain);
    c = cyc;
    chk("ren", ren, m == M_REQ);
    chk("busy", busy, m != M_IDLE);
    if (prev_rst) begin
      chk("rst_tx", tx, 1);
      chk("rst_done", byte_done, 0);
    end
    rnow = 0;
    if (rst_left > 0) begin
      rnow = 1;
      rst_left--;
    end else if (m == M_FRAME && c >= fstart + 2 && c <= fend - 3 &&
                 $urandom_range(99) < p_rst) begin
      rnow = 1;
      rst_left = 2;
    end
    rst = rnow;
    rvalid = 1'b0;
    rdata = 8'($urandom);
    empty = (src.size() == 0) || ($urandom_range(99) < p_hold);
    m_old = m;
    if (rnow) begin
      m = M_IDLE;
    end else begin
      case (m)
        M_IDLE: if (!empty) m = M_REQ;
        M_REQ: m = M_WAIT;
        M_WAIT: begin
          drop = force_drop || ($urandom_range(99) < p_drop) ||
                 (src.size() == 0);
          force_drop = 0;
          if (!drop) begin
            rvalid = 1'b1;
            rdata = src.pop_front();
            exp_q.push_back('{rdata, c + 1});
            fstart = c + 1;
            fend = c + L;
            m = M_FRAME;
          end else begin
            m = M_IDLE;
          end
        end
        M_FRAME: if (c == fend) m = M_IDLE;
        default: m = M_IDLE;
      endcase
    end
    if (m_old != M_WAIT && $urandom_range(99) < p_stray) begin
      rvalid = 1'b1;
      rdata = 8'hFF;
    end
    prev_rst = rnow;
  endtask

  initial begin
    rst_left = 3;
    repeat (5) step();

    src.push_back(8'hA5);
    repeat (60) step();

    src.push_back(8'h11);
    src.push_back(8'h22);
    repeat (110) step();

    force_drop = 1;
    src.push_back(8'h07);
    repeat (60) step();

    p_stray = 30;
    src.push_back(8'h03);
    repeat (60) step();
    p_stray = 0;

    p_rst = 100;
    src.push_back(8'h5A);
    repeat (40) step();
    p_rst = 0;
    src.push_back(8'hC3);
    repeat (60) step();

    p_hold = 25;
    p_drop = 10;
    p_stray = 10;
    p_rst = 1;
    repeat (4000) begin
      if (src.size() < 2 && $urandom_range(3) == 0)
        src.push_back(8'($urandom));
      step();
    end

    p_hold = 100;
    p_drop = 0;
    p_stray = 0;
    p_rst = 0;
    for (int i = 0; i < 200; i++) begin
      if (m == M_IDLE && exp_q.size() == 0) break;
      step();
    end
    repeat (3) step();
    chk("drain", (m == M_IDLE) && (exp_q.size() == 0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have port clk_single_domain  input  1  sole clock, rising-edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port empty  input  1  upstream FIFO empty flag.
REQ-005 SHALL have port rdata  input  8  upstream FIFO read data.
REQ-006 SHALL have port rvalid  input  1  upstream FIFO read-data-valid, one cycle after an accepted ren.
REQ-007 SHALL have port ren  output  1  FIFO read request, one-cycle pulse.
REQ-008 SHALL have port tx  output  1  serial line, idle high, registered.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port byte_done  output  1  one-cycle pulse at the end of each transmitted stop bit.

Function
REQ-011 SHALL implement states IDLE, REQ, WAIT, START, DATA, PARITY (only when the macro in REQ-027 is defined), and STOP.
REQ-012 IDLE: empty==0 -> REQ; else stay; tx=1.
REQ-013 REQ: ren=1 for exactly this cycle -> WAIT; ren SHALL be 0 in every other state.
REQ-014 WAIT lasts one cycle: rvalid==1 -> capture rdata into the shift register, go to START; rvalid==0 -> go to IDLE, nothing sent, no byte_done.
REQ-015 Latency: if IDLE samples empty==0 in cycle n, ren=1 in n+1 and tx=0 (start bit) from n+3.
REQ-016 Each of start, data, parity and stop bits SHALL hold tx for exactly CLKS_PER_BIT cycles, using a bit-timer counter of width clog2(CLKS_PER_BIT) that reloads at each bit boundary.
REQ-017 DATA SHALL send 8 bits LSB first, using a 3-bit index that wraps 7->0 on exit to PARITY or STOP.
REQ-018 STOP: tx=1; on the last timer cycle, byte_done=1 -> IDLE.
REQ-019 Frame length SHALL be 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
REQ-020 Back-to-back frames: at least 3 tx-high cycles (IDLE, REQ, WAIT) SHALL separate the end of a stop bit from the next start bit.
REQ-021 Changes on empty, rdata or rvalid outside IDLE/WAIT SHALL be ignored; a frame in progress is never aborted except by rst.
REQ-022 rvalid asserted in any state other than WAIT SHALL be ignored.

Reset
REQ-023 rst SHALL force state=IDLE, tx=1, ren=0, busy=0, byte_done=0, timer=0, bit index=0, shift register=0 at the next rising edge.
REQ-024 rst mid-frame SHALL drop the byte in progress; tx=1 from the cycle after the reset edge; no byte_done.
REQ-025 After rst deasserts, the first possible ren is one cycle after IDLE samples empty==0.
REQ-026 SHALL contain no asynchronous reset logic.

Configuration
REQ-027 With macro FIFO_UART_TX_PARITY_EN defined, SHALL insert an even-parity bit (XOR of the 8 data bits) between bit 7 and the stop bit via state PARITY.
REQ-028 Without FIFO_UART_TX_PARITY_EN, PARITY state and parity logic SHALL be absent; DATA goes directly to STOP.

Verification (CLKS_PER_BIT=4)
REQ-029 rst held 3 cycles mid-frame -> tx=1, busy=0, ren=0 the cycle after the reset edge; no byte_done.
REQ-030 empty=0 with 0xA5 returned via rvalid, no parity -> ren pulse 1 cycle; tx = 0, then 1,0,1,0,0,1,0,1, then 1, each 4 cycles; byte_done 40 cycles after start-bit onset minus 1.
REQ-031 Same stimulus with FIFO_UART_TX_PARITY_EN, byte 0x07 -> parity bit 1, frame 44 cycles; byte 0x03 -> parity bit 0.
REQ-032 Two bytes 0x11, 0x22 queued (empty stays 0) -> two frames, exactly 3 tx-high cycles between stop end and second start; two byte_done pulses.
REQ-033 empty=0 but rvalid=0 in WAIT -> return to IDLE, tx stays 1, no byte_done; next ren one cycle later if empty still 0.
REQ-034 Stray rvalid=1 pulse during DATA with rdata=0xFF -> frame bits unchanged.
